// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache with LL/SC link
// register and a halt-triggered flush of every dirty frame.
module dcache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic [2:0] {
    IDLE, WB, FETCH, FLUSH, DONE
  } state_t;

  state_t state, state_n;

  logic [SETS-1:0] valid, dirty;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS];
  logic            link_valid;
  logic [29:0]     link_addr;
  logic [IW-1:0]   fidx;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit, vdirty, fdirty;
  logic          sc, link_match, do_store;
  logic          st_write, fill, clr_dirty, fadv;
  logic          set_link, clr_link;
  logic [IW-1:0] clr_idx;
  logic          unused;

  assign idx        = dmemaddr[IW+1:2];
  assign tag        = dmemaddr[31:IW+2];
  assign hit        = valid[idx] && (tags[idx] == tag);
  assign vdirty     = valid[idx] && dirty[idx];
  assign fdirty     = valid[fidx] && dirty[fidx];
  assign sc         = datomic && dmemWEN;
  assign link_match = link_valid && (link_addr == dmemaddr[31:2]);
  assign do_store   = dmemWEN && (!sc || link_match);
  assign flushed    = (state == DONE);
  assign unused     = ^dmemaddr[1:0];

  always_comb begin
    state_n  = state;
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    st_write = 1'b0;
    fill     = 1'b0;
    clr_dirty = 1'b0;
    clr_idx  = idx;
    fadv     = 1'b0;
    set_link = 1'b0;
    clr_link = 1'b0;
    unique case (state)
      IDLE: begin
        if (dmemWEN) begin
          if (!do_store) begin
            dhit = 1'b1;
          end else if (hit || !vdirty) begin
            // clean or empty victim is simply overwritten
            dhit     = 1'b1;
            st_write = 1'b1;
            dmemload = {31'b0, sc};
            clr_link = link_match;
          end else begin
            state_n = WB;
          end
        end else if (dmemREN) begin
          if (hit) begin
            dhit     = 1'b1;
            dmemload = data[idx];
            set_link = datomic;
          end else if (vdirty) begin
            state_n = WB;
          end else begin
            state_n = FETCH;
          end
        end else if (halt) begin
          state_n = FLUSH;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {tags[idx], idx, 2'b00};
        dstore = data[idx];
        if (!dwait) begin
          clr_dirty = 1'b1;
          state_n   = dmemWEN ? IDLE : FETCH;
        end
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      FLUSH: begin
        clr_idx = fidx;
        if (fdirty) begin
          dWEN   = 1'b1;
          daddr  = {tags[fidx], fidx, 2'b00};
          dstore = data[fidx];
          if (!dwait) begin
            clr_dirty = 1'b1;
            fadv      = 1'b1;
          end
        end else begin
          fadv = 1'b1;
        end
        if (fadv && fidx == IW'(SETS - 1)) state_n = DONE;
      end
      DONE: begin
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
      fidx       <= '0;
      for (int i = 0; i < SETS; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (st_write) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b1;
        tags[idx]  <= tag;
        data[idx]  <= dmemstore;
      end
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
        tags[idx]  <= tag;
        data[idx]  <= dload;
      end
      if (clr_dirty) dirty[clr_idx] <= 1'b0;
      if (fadv) fidx <= fidx + 1'b1;
      if (set_link) begin
        link_valid <= 1'b1;
        link_addr  <= dmemaddr[31:2];
      end else if (clr_link) begin
        link_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: misses, write-back, LL/SC, flush and
// reset abort, against a latency-programmable word memory.
module tb_dcache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN, datomic, halt;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed;
  logic [31:0] dmemload;
  logic        dwait;
  logic [31:0] dload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;

  int checks = 0;
  int errors = 0;

  dcache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dwait(dwait), .dload(dload), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore)
  );

  always #5 CLK = ~CLK;

  // memory model: untouched words read as a fixed address pattern
  logic [31:0] mem [1024];
  logic [1023:0] wr = '0;
  int lat = 0;
  int cnt = 0;
  int ren_cycles = 0;
  int overlap = 0;
  int unstable = 0;
  int wcount = 0;
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  logic held = 1'b0;
  logic [31:0] pa, pd;
  logic pr, pw;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  assign dwait = (dREN || dWEN) && (cnt < lat);
  assign dload = wr[daddr[11:2]] ? mem[daddr[11:2]] : pat(daddr);

  always @(posedge CLK) begin
    if (dREN && dWEN) overlap <= overlap + 1;
    if (dREN) ren_cycles <= ren_cycles + 1;
    if (held && (dREN || dWEN) &&
        (daddr !== pa || dstore !== pd || dREN !== pr || dWEN !== pw))
      unstable <= unstable + 1;
    held <= (dREN || dWEN) && dwait;
    pa <= daddr; pd <= dstore; pr <= dREN; pw <= dWEN;
    if (dREN || dWEN) cnt <= dwait ? cnt + 1 : 0;
    else cnt <= 0;
    if (dWEN && !dwait) begin
      mem[daddr[11:2]] <= dstore;
      wr[daddr[11:2]]  <= 1'b1;
      wa[wcount[5:0]]  <= daddr;
      wd[wcount[5:0]]  <= dstore;
      wcount <= wcount + 1;
    end
  end

  task automatic apply_reset();
    nRST = 1'b0;
    dmemREN = 0; dmemWEN = 0; datomic = 0; halt = 0;
    dmemaddr = '0; dmemstore = '0;
    #3;
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic req(input logic r, input logic w, input logic a,
                     input logic [31:0] addr, input logic [31:0] sd,
                     output int n, output logic [31:0] ld);
    dmemREN = r; dmemWEN = w; datomic = a;
    dmemaddr = addr; dmemstore = sd;
    n = -1; ld = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (dhit) begin n = i; ld = dmemload; break; end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    dmemREN = 0; dmemWEN = 0; datomic = 0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    dmemREN = 0; dmemWEN = 0; datomic = 0; halt = 0;
    dmemaddr = '0; dmemstore = '0;
    @(posedge CLK); @(negedge CLK);
    checks++; if ({dhit, dREN, dWEN, flushed} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0000", {dhit, dREN, dWEN, flushed}); end
    checks++; if (daddr !== 32'h0 || dstore !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h/%h want 0/0", daddr, dstore); end
    checks++; if (dmemload !== 32'h0) begin errors++; $display("FAIL reset_load: got %h want 0", dmemload); end
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_load_miss();
    int n, r0;
    logic [31:0] ld;
    lat = 2;
    r0 = ren_cycles;
    req(1, 0, 0, 32'h40, 0, n, ld);
    checks++; if (n !== 4) begin errors++; $display("FAIL miss_lat: got %0d want 4", n); end
    checks++; if (ren_cycles - r0 !== 3) begin errors++; $display("FAIL miss_ren: got %0d want 3", ren_cycles - r0); end
    checks++; if (ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_data: got %h want deadbeef", ld); end
    r0 = ren_cycles;
    req(1, 0, 0, 32'h40, 0, n, ld);
    checks++; if (n !== 0 || ren_cycles - r0 !== 0) begin errors++; $display("FAIL hit_lat: got %0d/%0d want 0/0", n, ren_cycles - r0); end
    checks++; if (ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_data: got %h want deadbeef", ld); end
    lat = 0;
  endtask

  task automatic test_writeback();
    int n, r0, w0;
    logic [31:0] ld;
    req(0, 1, 0, 32'h40, 32'h1111_1111, n, ld);
    checks++; if (n !== 0 || ld !== 32'h0) begin errors++; $display("FAIL st_hit: got %0d/%h want 0/0", n, ld); end
    r0 = ren_cycles; w0 = wcount;
    req(1, 0, 0, 32'h440, 0, n, ld);
    checks++; if (n !== 3) begin errors++; $display("FAIL wb_lat: got %0d want 3", n); end
    checks++; if (wcount - w0 !== 1 || ren_cycles - r0 !== 1) begin errors++; $display("FAIL wb_xfers: got %0d/%0d want 1/1", wcount - w0, ren_cycles - r0); end
    checks++; if (wa[w0] !== 32'h40 || wd[w0] !== 32'h1111_1111) begin errors++; $display("FAIL wb_word: got %h/%h want 40/11111111", wa[w0], wd[w0]); end
    checks++; if (ld !== 32'hC0DE_0440) begin errors++; $display("FAIL wb_fill: got %h want c0de0440", ld); end
  endtask

  task automatic test_llsc();
    int n;
    logic [31:0] ld;
    req(1, 0, 1, 32'h80, 0, n, ld);
    checks++; if (n !== 2 || ld !== 32'hC0DE_0080) begin errors++; $display("FAIL ll: got %0d/%h want 2/c0de0080", n, ld); end
    req(0, 1, 1, 32'h80, 32'h5, n, ld);
    checks++; if (n !== 0 || ld !== 32'h1) begin errors++; $display("FAIL sc_ok: got %0d/%h want 0/1", n, ld); end
    req(1, 0, 0, 32'h80, 0, n, ld);
    checks++; if (ld !== 32'h5) begin errors++; $display("FAIL sc_data: got %h want 5", ld); end
    req(0, 1, 1, 32'h80, 32'h7, n, ld);
    checks++; if (n !== 0 || ld !== 32'h0) begin errors++; $display("FAIL sc_again: got %0d/%h want 0/0", n, ld); end
    req(1, 0, 0, 32'h80, 0, n, ld);
    checks++; if (ld !== 32'h5) begin errors++; $display("FAIL sc_nowrite: got %h want 5", ld); end
  endtask

  task automatic test_ll_store_sc();
    int n;
    logic [31:0] ld;
    req(1, 0, 1, 32'h80, 0, n, ld);
    checks++; if (n !== 0 || ld !== 32'h5) begin errors++; $display("FAIL ll_hit: got %0d/%h want 0/5", n, ld); end
    req(0, 1, 0, 32'h80, 32'h9, n, ld);
    req(0, 1, 1, 32'h80, 32'hA, n, ld);
    checks++; if (n !== 0 || ld !== 32'h0) begin errors++; $display("FAIL sc_broken: got %0d/%h want 0/0", n, ld); end
    req(1, 0, 0, 32'h80, 0, n, ld);
    checks++; if (ld !== 32'h9) begin errors++; $display("FAIL sc_broken_data: got %h want 9", ld); end
  endtask

  task automatic test_flush_dirty();
    int n, w0, hits, rens;
    logic [31:0] ld;
    apply_reset();
    lat = 1;
    req(0, 1, 0, 32'h0C, 32'h33, n, ld);
    req(0, 1, 0, 32'h24, 32'h99, n, ld);
    checks++; if (n !== 0) begin errors++; $display("FAIL fl_store: got %0d want 0", n); end
    w0 = wcount;
    halt = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (flushed) break;
    end
    checks++; if (flushed !== 1'b1) begin errors++; $display("FAIL fl_done: got %b want 1", flushed); end
    checks++; if (wcount - w0 !== 2) begin errors++; $display("FAIL fl_count: got %0d want 2", wcount - w0); end
    checks++; if (wa[w0] !== 32'h0C || wd[w0] !== 32'h33) begin errors++; $display("FAIL fl_first: got %h/%h want c/33", wa[w0], wd[w0]); end
    checks++; if (wa[w0+1] !== 32'h24 || wd[w0+1] !== 32'h99) begin errors++; $display("FAIL fl_second: got %h/%h want 24/99", wa[w0+1], wd[w0+1]); end
    @(posedge CLK); #1;
    halt = 1'b0;
    dmemREN = 1'b1; dmemaddr = 32'h0C;
    hits = 0; rens = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (dhit) hits++;
      if (dREN || dWEN) rens++;
    end
    checks++; if (hits !== 0 || rens !== 0 || flushed !== 1'b1) begin errors++; $display("FAIL done_idle: got %0d/%0d/%b want 0/0/1", hits, rens, flushed); end
    @(posedge CLK); #1;
    dmemREN = 1'b0;
    lat = 0;
  endtask

  task automatic test_flush_clean();
    int c;
    apply_reset();
    halt = 1'b1;
    c = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (flushed) break;
      c++;
    end
    checks++; if (c !== 17) begin errors++; $display("FAIL fl_clean: got %0d want 17", c); end
    @(posedge CLK); #1;
    halt = 1'b0;
  endtask

  task automatic test_reset_fetch();
    int n;
    logic [31:0] ld;
    apply_reset();
    lat = 0;
    req(0, 1, 0, 32'h0C, 32'h77, n, ld);
    lat = 5;
    dmemREN = 1'b1; dmemaddr = 32'h100;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++; if (dREN !== 1'b1) begin errors++; $display("FAIL rf_fetch: got %b want 1", dREN); end
    #2 nRST = 1'b0;
    #1;
    checks++; if (dREN !== 1'b0 || daddr !== 32'h0) begin errors++; $display("FAIL rf_abort: got %b/%h want 0/0", dREN, daddr); end
    dmemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    lat = 0;
    req(1, 0, 0, 32'h0C, 0, n, ld);
    checks++; if (n !== 2 || ld !== 32'h33) begin errors++; $display("FAIL rf_miss: got %0d/%h want 2/33", n, ld); end
  endtask

  task automatic test_protocol();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL ren_wen_overlap: got %0d want 0", overlap); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL hold_stable: got %0d want 0", unstable); end
  endtask

  initial begin
    nRST = 1'b0;
    dmemREN = 0; dmemWEN = 0; datomic = 0; halt = 0;
    dmemaddr = '0; dmemstore = '0;
    test_reset();
    test_load_miss();
    test_writeback();
    test_llsc();
    test_ll_store_sc();
    test_flush_dirty();
    test_flush_clean();
    test_reset_fetch();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
